// File: rtl/seq_mem_arbiter_2p.sv
// -----------------------------------------------------------------------------
// seq_mem_arbiter_2p
//
// Purpose:
//   Shares one single-port sequential memory (1-cycle latency, read_en /
//   write_en / addr0 / in -> out, read_done, write_done) between two
//   requesters that use a level go / pulse done handshake. Requests are
//   arbitrated round-robin and each access is serialised through a
//   four-state FSM (IDLE -> ISSUE -> WAIT -> RESP). Read results are returned
//   on a private per-port register that only that port's reads update.
//
// Parameters:
//   WIDTH     data width (matches the memory WIDTH)
//   IDX_SIZE  address width (matches the memory IDX_SIZE)
//   STAT_W    grant-counter width (only meaningful with SEQ_ARB_STATS_EN)
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   goN, weN, addrN,    requester N: level request held until doneN,
//   wdataN              1=write/0=read, address and write data
//   doneN               one-cycle completion pulse for requester N
//   rdataN              last read result for requester N
//   mem_addr0, mem_in,  registered address / data and one-cycle
//   mem_read_en,        read / write strobes to the memory
//   mem_write_en
//   mem_out,            memory read data and completion flags
//   mem_read_done,
//   mem_write_done
//   grant_cnt0/1        saturating per-port grant counters
//                       (present only when SEQ_ARB_STATS_EN is defined)
//
// Configuration macro:
//   SEQ_ARB_STATS_EN    adds the grant_cnt0 / grant_cnt1 outputs.
// -----------------------------------------------------------------------------
module seq_mem_arbiter_2p #(
    parameter int WIDTH    = 32,
    parameter int IDX_SIZE = 2,
    parameter int STAT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                go0,
    input  logic                we0,
    input  logic [IDX_SIZE-1:0] addr0,
    input  logic [WIDTH-1:0]    wdata0,
    output logic                done0,
    output logic [WIDTH-1:0]    rdata0,

    input  logic                go1,
    input  logic                we1,
    input  logic [IDX_SIZE-1:0] addr1,
    input  logic [WIDTH-1:0]    wdata1,
    output logic                done1,
    output logic [WIDTH-1:0]    rdata1,

    output logic [IDX_SIZE-1:0] mem_addr0,
    output logic [WIDTH-1:0]    mem_in,
    output logic                mem_read_en,
    output logic                mem_write_en,
    input  logic [WIDTH-1:0]    mem_out,
    input  logic                mem_read_done,
    input  logic                mem_write_done
`ifdef SEQ_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   grant_cnt0,
    output logic [STAT_W-1:0]   grant_cnt1
`endif
);

    // Elaboration-time sanity check on the configuration.
    if (WIDTH < 1 || IDX_SIZE < 1 || STAT_W < 1) begin : g_bad_params
        $error("seq_mem_arbiter_2p: WIDTH, IDX_SIZE and STAT_W must be positive");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;

    // Granted port and round-robin pointer (value = port currently favoured).
    logic                grant_q, grant_d;
    logic                rr_q, rr_d;

    // Latched access description for the granted port.
    logic                we_q, we_d;
    logic [IDX_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]    mem_in_q, mem_in_d;

    // Per-port read-result registers.
    logic [WIDTH-1:0]    rdata0_q, rdata0_d;
    logic [WIDTH-1:0]    rdata1_q, rdata1_d;

    logic                any_req;
    logic                pick;
    logic                op_done;

    assign any_req = go0 | go1;

    // With both requests up the rr pointer decides; otherwise the sole
    // requester wins (go1 alone -> 1, go0 alone -> 0).
    assign pick = (go0 && go1) ? rr_q : go1;

    // Only the completion flag of the issued operation matters; the other
    // one is ignored even if the memory happens to raise it.
    assign op_done = we_q ? mem_write_done : mem_read_done;

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (op_done) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM outputs: strobes in ISSUE, completion pulse in RESP
    // ---------------------------------------------------------------------
    always_comb begin
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        done0        = 1'b0;
        done1        = 1'b0;
        case (state_q)
            S_ISSUE: begin
                mem_read_en  = ~we_q;
                mem_write_en = we_q;
            end
            S_RESP: begin
                done0 = ~grant_q;
                done1 = grant_q;
            end
            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath next-state: grant latch, read capture, rr update
    // ---------------------------------------------------------------------
    always_comb begin
        grant_d    = grant_q;
        rr_d       = rr_q;
        we_d       = we_q;
        mem_addr_d = mem_addr_q;
        mem_in_d   = mem_in_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        if (state_q == S_IDLE && any_req) begin
            grant_d    = pick;
            we_d       = pick ? we1    : we0;
            mem_addr_d = pick ? addr1  : addr0;
            mem_in_d   = pick ? wdata1 : wdata0;
        end

        // Only reads touch rdataN, so a write that disturbs mem_out can
        // never leak into a requester's result register.
        if (state_q == S_WAIT && op_done && !we_q) begin
            if (grant_q) begin
                rdata1_d = mem_out;
            end else begin
                rdata0_d = mem_out;
            end
        end

        if (state_q == S_RESP) begin
            rr_d = ~grant_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q    <= 1'b0;
            rr_q       <= 1'b0;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_in_q   <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            we_q       <= we_d;
            mem_addr_q <= mem_addr_d;
            mem_in_q   <= mem_in_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign mem_addr0 = mem_addr_q;
    assign mem_in    = mem_in_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

`ifdef SEQ_ARB_STATS_EN
    // ---------------------------------------------------------------------
    // Saturating grant counters, bumped on the WAIT -> RESP transition
    // ---------------------------------------------------------------------
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic              resp_entry;
    logic [STAT_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [STAT_W-1:0] grant_cnt1_q, grant_cnt1_d;

    assign resp_entry = (state_q == S_WAIT) && op_done;

    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (resp_entry) begin
            if (!grant_q && grant_cnt0_q != '1) begin
                grant_cnt0_d = grant_cnt0_q + STAT_ONE;
            end
            if (grant_q && grant_cnt1_q != '1) begin
                grant_cnt1_d = grant_cnt1_q + STAT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_seq_mem_arbiter_2p.sv
// -----------------------------------------------------------------------------
// tb_seq_mem_arbiter_2p
//
// Self-checking bench for seq_mem_arbiter_2p. A behavioural 1-cycle-latency
// memory sits on the mem_* side; a write disturbs mem_out on purpose. Each
// request pushes its expected completion (port, read data) into a queue and a
// negedge monitor pops and compares whenever a doneN pulse appears.
// -----------------------------------------------------------------------------
module tb_seq_mem_arbiter_2p;

    localparam int W  = 32;
    localparam int IS = 2;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          go0, we0, go1, we1;
    logic [IS-1:0] addr0, addr1;
    logic [W-1:0]  wdata0, wdata1;
    logic          done0, done1;
    logic [W-1:0]  rdata0, rdata1;
    logic [IS-1:0] mem_addr0;
    logic [W-1:0]  mem_in;
    logic          mem_read_en, mem_write_en;
    logic [W-1:0]  mem_out = '0;
    logic          mem_read_done = 1'b0;
    logic          mem_write_done = 1'b0;
`ifdef SEQ_ARB_STATS_EN
    logic [SW-1:0] grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    seq_mem_arbiter_2p #(
        .WIDTH    (W),
        .IDX_SIZE (IS),
        .STAT_W   (SW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .go0            (go0),
        .we0            (we0),
        .addr0          (addr0),
        .wdata0         (wdata0),
        .done0          (done0),
        .rdata0         (rdata0),
        .go1            (go1),
        .we1            (we1),
        .addr1          (addr1),
        .wdata1         (wdata1),
        .done1          (done1),
        .rdata1         (rdata1),
        .mem_addr0      (mem_addr0),
        .mem_in         (mem_in),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_out        (mem_out),
        .mem_read_done  (mem_read_done),
        .mem_write_done (mem_write_done)
`ifdef SEQ_ARB_STATS_EN
        ,
        .grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1)
`endif
    );

    // Behavioural sequential memory with a preload port.
    logic [W-1:0]  mem [4];
    logic          pre_en = 1'b0;
    logic [IS-1:0] pre_addr = '0;
    logic [W-1:0]  pre_data = '0;

    always @(posedge clk) begin
        mem_read_done  <= 1'b0;
        mem_write_done <= 1'b0;
        if (pre_en) mem[pre_addr] <= pre_data;
        if (mem_read_en) begin
            mem_out       <= mem[mem_addr0];
            mem_read_done <= 1'b1;
        end
        if (mem_write_en) begin
            mem[mem_addr0] <= mem_in;
            mem_out        <= ~mem_in;
            mem_write_done <= 1'b1;
        end
    end

    // Scoreboard
    typedef struct packed {
        logic         port;
        logic         is_read;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] ref_mem [4];
    int           total = 0;
    int           bad = 0;
    int           wr_cnt = 0;

    always @(negedge clk) begin
        exp_t         e;
        logic [W-1:0] got;
        if (reset === 1'b0) begin
            if (mem_write_en === 1'b1) wr_cnt++;
            if (mem_read_en === 1'b1 || mem_write_en === 1'b1) begin
                total++;
                if (mem_read_en === 1'b1 && mem_write_en === 1'b1) begin
                    bad++;
                    $display("FAIL mem_en_excl read_en=%0b write_en=%0b required not both 1",
                             mem_read_en, mem_write_en);
                end
            end
            if (done0 === 1'b1 || done1 === 1'b1) begin
                total++;
                if (done0 === 1'b1 && done1 === 1'b1) begin
                    bad++;
                    $display("FAIL sb_done_both done0=1 done1=1 required one-hot");
                end else if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected done0=%0b done1=%0b required no done", done0, done1);
                end else begin
                    e   = exp_q.pop_front();
                    got = (done1 === 1'b1) ? rdata1 : rdata0;
                    if (done1 !== e.port) begin
                        bad++;
                        $display("FAIL sb_port got=%0d required=%0d", done1, e.port);
                    end else if (e.is_read && got !== e.data) begin
                        bad++;
                        $display("FAIL sb_rdata port=%0d got=%h required=%h", e.port, got, e.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        total++;
        if ({done0, done1, mem_read_en, mem_write_en, mem_addr0, mem_in, rdata0, rdata1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=0",
                     {done0, done1, mem_read_en, mem_write_en, mem_addr0, mem_in, rdata0, rdata1});
        end
`ifdef SEQ_ARB_STATS_EN
        total++;
        if ({grant_cnt0, grant_cnt1} !== '0) begin
            bad++;
            $display("FAIL reset_cnt got=%h required=0", {grant_cnt0, grant_cnt1});
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({done0, done1, mem_read_en, mem_write_en} !== 4'b0) begin
            bad++;
            $display("FAIL idle_quiet got=%b required=0000", {done0, done1, mem_read_en, mem_write_en});
        end
    endtask

    task automatic test_read_single();
        int n = 0;
        @(negedge clk);
        go0 = 1'b1; we0 = 1'b0; addr0 = 2'd0; wdata0 = '0;
        exp_q.push_back('{port: 1'b0, is_read: 1'b1, data: ref_mem[0]});
        while (done0 !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                total++;
                if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0) begin
                    bad++;
                    $display("FAIL t1_issue read_en=%0b write_en=%0b required 1/0", mem_read_en, mem_write_en);
                end
            end
        end
        go0 = 1'b0;
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL t1_latency got=%0d required=3", n);
        end
        total++;
        if (rdata0 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL t1_rdata got=%h required=deadbeef", rdata0);
        end
    endtask

    task automatic test_write_then_read();
        int n = 0, d0_at = 0, d1_at = 0;
        wr_cnt = 0;
        @(negedge clk);
        go0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 32'h12345678;
        ref_mem[0] = 32'h12345678;
        exp_q.push_back('{port: 1'b0, is_read: 1'b0, data: '0});
        exp_q.push_back('{port: 1'b1, is_read: 1'b1, data: ref_mem[0]});
        while (d1_at == 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                go1 = 1'b1; we1 = 1'b0; addr1 = 2'd0; wdata1 = 32'h0F0F0F0F;
            end
            if (done0 === 1'b1) begin d0_at = n; go0 = 1'b0; end
            if (done1 === 1'b1) begin d1_at = n; go1 = 1'b0; end
        end
        total++;
        if (d0_at != 3 || d1_at != 7) begin
            bad++;
            $display("FAIL t2_timing done0_at=%0d done1_at=%0d required 3/7", d0_at, d1_at);
        end
        total++;
        if (wr_cnt != 1) begin
            bad++;
            $display("FAIL t2_write_once got=%0d required=1", wr_cnt);
        end
        total++;
        if (rdata1 !== 32'h12345678) begin
            bad++;
            $display("FAIL t2_rdata1 got=%h required=12345678", rdata1);
        end
        total++;
        if (rdata0 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL t2_rdata0_kept got=%h required=deadbeef", rdata0);
        end
        @(negedge clk);
        total++;
        if (mem_addr0 !== 2'd0 || mem_in !== 32'h0F0F0F0F) begin
            bad++;
            $display("FAIL t2_hold addr=%0d in=%h required 0/0f0f0f0f", mem_addr0, mem_in);
        end
    endtask

    task automatic test_both_from_reset();
        int n = 0, d0_at = 0, d1_at = 0;
        @(negedge clk);
        reset = 1'b1;
        go0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
        go1 = 1'b1; we1 = 1'b0; addr1 = 2'd1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back('{port: 1'b0, is_read: 1'b1, data: ref_mem[0]});
        exp_q.push_back('{port: 1'b1, is_read: 1'b1, data: ref_mem[1]});
        while (d1_at == 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (done0 === 1'b1) begin d0_at = n; go0 = 1'b0; end
            if (done1 === 1'b1) begin d1_at = n; go1 = 1'b0; end
        end
        total++;
        if (d0_at != 3 || d1_at != 7) begin
            bad++;
            $display("FAIL t3_timing done0_at=%0d done1_at=%0d required 3/7", d0_at, d1_at);
        end
        total++;
        if (rdata0 !== ref_mem[0] || rdata1 !== ref_mem[1]) begin
            bad++;
            $display("FAIL t3_rdata got=%h/%h required=%h/%h", rdata0, rdata1, ref_mem[0], ref_mem[1]);
        end
    endtask

    task automatic test_alternate();
        int n = 0, k = 0, last = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        go0 = 1'b1; we0 = 1'b0; addr0 = 2'd2;
        go1 = 1'b1; we1 = 1'b0; addr1 = 2'd3;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{port: i[0], is_read: 1'b1, data: ref_mem[i[0] ? 3 : 2]});
        end
        while (k < 8 && n < 60) begin
            @(negedge clk);
            n++;
            if (done0 === 1'b1 || done1 === 1'b1) begin
                total++;
                if (done1 !== k[0]) begin
                    bad++;
                    $display("FAIL t4_order grant=%0d got_port=%0d required=%0d", k, done1, k[0]);
                end
                total++;
                if ((k == 0 && n != 3) || (k > 0 && n - last != 4)) begin
                    bad++;
                    $display("FAIL t4_spacing grant=%0d cycle=%0d prev=%0d required first=3 gap=4", k, n, last);
                end
                last = n;
                k++;
                if (k == 8) begin go0 = 1'b0; go1 = 1'b0; end
            end
        end
        go0 = 1'b0; go1 = 1'b0;
        total++;
        if (k != 8) begin
            bad++;
            $display("FAIL t4_count got=%0d required=8", k);
        end
    endtask

    task automatic test_reset_in_wait();
        int n = 0;
        @(negedge clk);
        go0 = 1'b1; we0 = 1'b0; addr0 = 2'd3;
        exp_q.push_back('{port: 1'b0, is_read: 1'b1, data: ref_mem[3]});
        repeat (2) @(negedge clk);
        reset = 1'b1;
        go0 = 1'b0;
        void'(exp_q.pop_back());
        #1;
        total++;
        if ({done0, done1, mem_read_en, mem_write_en, mem_addr0, mem_in, rdata0, rdata1} !== '0) begin
            bad++;
            $display("FAIL t5_async_clear got=%h required=0",
                     {done0, done1, mem_read_en, mem_write_en, mem_addr0, mem_in, rdata0, rdata1});
        end
        repeat (2) begin
            @(negedge clk);
            total++;
            if (done0 !== 1'b0 || done1 !== 1'b0) begin
                bad++;
                $display("FAIL t5_no_done done0=%0b done1=%0b required 0/0", done0, done1);
            end
        end
        reset = 1'b0;
        go0 = 1'b1; we0 = 1'b0; addr0 = 2'd1;
        exp_q.push_back('{port: 1'b0, is_read: 1'b1, data: ref_mem[1]});
        while (done0 !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        go0 = 1'b0;
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL t5_latency got=%0d required=3", n);
        end
        total++;
        if (rdata0 !== ref_mem[1] || rdata1 !== '0) begin
            bad++;
            $display("FAIL t5_rdata got=%h/%h required=%h/0", rdata0, rdata1, ref_mem[1]);
        end
    endtask

`ifdef SEQ_ARB_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (grant_cnt0 !== '0 || grant_cnt1 !== '0) begin
            bad++;
            $display("FAIL t6_clear got=%0d/%0d required 0/0", grant_cnt0, grant_cnt1);
        end
        for (int g = 0; g < 5; g++) begin
            int n = 0;
            @(negedge clk);
            go0 = 1'b1; we0 = 1'b0; addr0 = 2'd2;
            exp_q.push_back('{port: 1'b0, is_read: 1'b1, data: ref_mem[2]});
            while (done0 !== 1'b1 && n < 12) begin
                @(negedge clk);
                n++;
            end
            go0 = 1'b0;
            if (g == 1) begin
                total++;
                if (grant_cnt0 !== 2'd2) begin
                    bad++;
                    $display("FAIL t6_count2 got=%0d required=2", grant_cnt0);
                end
            end
        end
        total++;
        if (grant_cnt0 !== 2'd3 || grant_cnt1 !== 2'd0) begin
            bad++;
            $display("FAIL t6_saturate got=%0d/%0d required 3/0", grant_cnt0, grant_cnt1);
        end
    endtask
`endif

    logic [W-1:0] init_vals [4];

    initial begin
        init_vals = '{32'hDEADBEEF, 32'hA5A50001, 32'h0BADF00D, 32'hC001CAFE};
        reset = 1'b1;
        go0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        go1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pre_en   = 1'b1;
            pre_addr = IS'(i);
            pre_data = init_vals[i];
            ref_mem[i] = init_vals[i];
        end
        @(negedge clk);
        pre_en = 1'b0;

        test_reset();
        test_read_single();
        test_write_then_read();
        test_both_from_reset();
        test_alternate();
        test_reset_in_wait();
`ifdef SEQ_ARB_STATS_EN
        test_stats();
`endif
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
